// File: rtl/processor.sv
// Multi-cycle 16-bit accumulator processor: R0-R7, A/G ALU registers, shared bus, 4-step instruction cycle.
// Optional build macro PROC_DONE_EN adds a 'done' output that is high during T3.
module processor (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] iin,
  output logic [15:0] bus
`ifdef PROC_DONE_EN
  ,
  output logic        done
`endif
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAN  = 3'b010,
    OP_NOP0 = 3'b011,
    OP_OUT  = 3'b100,
    OP_LDI  = 3'b101,
    OP_NOP1 = 3'b110,
    OP_REP  = 3'b111
  } opcode_t;

  step_t       step;
  logic [15:0] ir;
  logic [15:0] regs [8];
  logic [15:0] a;
  logic [15:0] g;

  opcode_t     opcode;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [15:0] imm;
  logic [15:0] rx_val;
  logic [15:0] ry_val;
  logic        is_alu;
  logic [15:0] alu_result;

  assign opcode = opcode_t'(ir[15:13]);
  assign rx     = ir[12:10];
  assign ry     = ir[9:7];
  assign imm    = {6'b0, ir[9:0]};
  assign rx_val = regs[rx];
  assign ry_val = regs[ry];

  always_comb begin
    is_alu = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_NAN: is_alu = 1'b1;
      default:                is_alu = 1'b0;
    endcase
  end

  // A holds the first operand latched in T1; the bus carries Ry in T2.
  always_comb begin
    alu_result = 16'h0000;
    case (opcode)
      OP_ADD:  alu_result = a + bus;
      OP_SUB:  alu_result = a - bus;
      OP_NAN:  alu_result = ~(a & bus);
      default: alu_result = 16'h0000;
    endcase
  end

  always_comb begin
    bus = 16'h0000;
    case (step)
      T0: bus = 16'h0000;
      T1: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_NAN, OP_OUT: bus = rx_val;
          OP_LDI:                         bus = imm;
          OP_REP:                         bus = ry_val;
          default:                        bus = 16'h0000;
        endcase
      end
      T2: begin
        if (is_alu) begin
          bus = ry_val;
        end else if (opcode == OP_OUT) begin
          bus = rx_val;
        end
      end
      T3: begin
        if (is_alu) begin
          bus = g;
        end else if (opcode == OP_OUT) begin
          bus = rx_val;
        end
      end
      default: bus = 16'h0000;
    endcase
  end

`ifdef PROC_DONE_EN
  assign done = (step == T3);
`endif

  // Step counter, IR and all datapath registers; at most one register write per cycle.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      step <= T0;
      ir   <= 16'h0000;
      a    <= 16'h0000;
      g    <= 16'h0000;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      case (step)
        T0: begin
          ir   <= iin;
          step <= T1;
        end
        T1: begin
          if (opcode == OP_LDI || opcode == OP_REP) begin
            regs[rx] <= bus;
          end else if (is_alu) begin
            a <= bus;
          end
          step <= T2;
        end
        T2: begin
          if (is_alu) begin
            g <= alu_result;
          end
          step <= T3;
        end
        T3: begin
          if (is_alu) begin
            regs[rx] <= bus;
          end
          step <= T0;
        end
        default: step <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: driver pushes hand-computed per-step bus values, a negedge monitor pops and compares.
module tb_processor;

  logic        clock;
  logic        resetn;
  logic [15:0] iin;
  logic [15:0] bus;
`ifdef PROC_DONE_EN
  logic        done;
`endif

  // Expected entry: bit 16 = done, bits 15:0 = bus
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          n_pass;
  int          n_total;

  processor dut (
    .clock  (clock),
    .resetn (resetn),
    .iin    (iin),
    .bus    (bus)
`ifdef PROC_DONE_EN
    ,
    .done   (done)
`endif
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [16:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_total++;
      if (bus === e[15:0]) begin
        n_pass++;
      end else begin
        $display("FAIL %s bus: got %h expected %h", nm, bus, e[15:0]);
      end
`ifdef PROC_DONE_EN
      n_total++;
      if (done === e[16]) begin
        n_pass++;
      end else begin
        $display("FAIL %s done: got %b expected %b", nm, done, e[16]);
      end
`endif
    end
  end

  // driver tasks
  task automatic push_exp(input logic d, input logic [15:0] b, input string nm);
    exp_q.push_back({d, b});
    name_q.push_back(nm);
  endtask

  task automatic apply_reset(input string nm);
    resetn = 1'b1;
    push_exp(1'b0, 16'h0000, {nm, "/rst0"});
    push_exp(1'b0, 16'h0000, {nm, "/rst1"});
    repeat (2) @(negedge clock);
    #1;
    @(posedge clock);
    #1;
    resetn = 1'b0;
  endtask

  task automatic issue(input logic [15:0] word, input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3, input string nm);
    iin = word;
    push_exp(1'b0, 16'h0000, {nm, "/T0"});
    push_exp(1'b0, e1, {nm, "/T1"});
    push_exp(1'b0, e2, {nm, "/T2"});
    push_exp(1'b1, e3, {nm, "/T3"});
    repeat (4) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Starts an instruction and asserts reset right after its T2 has been sampled.
  task automatic issue_abort_t2(input logic [15:0] word, input logic [15:0] e1, input logic [15:0] e2,
                                input string nm);
    iin = word;
    push_exp(1'b0, 16'h0000, {nm, "/T0"});
    push_exp(1'b0, e1, {nm, "/T1"});
    push_exp(1'b0, e2, {nm, "/T2"});
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    #1;
    apply_reset({nm, "/abort"});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    iin     = 16'h0000;
    resetn  = 1'b1;
    apply_reset("init");

    // 28 - 10 = 18
    issue(16'hA01C, 16'd28, 16'h0000, 16'h0000, "ldi_r0_28");
    issue(16'hA40A, 16'd10, 16'h0000, 16'h0000, "ldi_r1_10");
    issue(16'h2080, 16'd28, 16'd10,   16'd18,   "sub_r0_r1");
    issue(16'h8000, 16'd18, 16'd18,   16'd18,   "out_r0_18");
    issue(16'h8400, 16'd10, 16'd10,   16'd10,   "out_r1_10");

    // ~(15 & 7) = 0xFFF8
    issue(16'hA80F, 16'd15,   16'h0000, 16'h0000, "ldi_r2_15");
    issue(16'hAC07, 16'd7,    16'h0000, 16'h0000, "ldi_r3_7");
    issue(16'h4980, 16'd15,   16'd7,    16'hFFF8, "nan_r2_r3");
    issue(16'hF500, 16'hFFF8, 16'h0000, 16'h0000, "rep_r5_r2");
    issue(16'h9400, 16'hFFF8, 16'hFFF8, 16'hFFF8, "out_r5");

    // 20 + 8 - 5 = 23
    issue(16'hA414, 16'd20, 16'h0000, 16'h0000, "ldi_r1_20");
    issue(16'hB008, 16'd8,  16'h0000, 16'h0000, "ldi_r4_8");
    issue(16'h0600, 16'd20, 16'd8,    16'd28,   "add_r1_r4");
    issue(16'hB805, 16'd5,  16'h0000, 16'h0000, "ldi_r6_5");
    issue(16'h2700, 16'd28, 16'd5,    16'd23,   "sub_r1_r6");
    issue(16'hFC80, 16'd23, 16'h0000, 16'h0000, "rep_r7_r1");
    issue(16'h9C00, 16'd23, 16'd23,   16'd23,   "out_r7_23");

    // wrap-around both ways
    issue(16'hA000, 16'h0000, 16'h0000, 16'h0000, "ldi_r0_0");
    issue(16'hA401, 16'd1,    16'h0000, 16'h0000, "ldi_r1_1");
    issue(16'h2080, 16'h0000, 16'd1,    16'hFFFF, "sub_wrap");
    issue(16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, "out_ffff");
    issue(16'h0080, 16'hFFFF, 16'd1,    16'h0000, "add_wrap");
    issue(16'h8000, 16'h0000, 16'h0000, 16'h0000, "out_zero");

    // Rx == Ry, max immediate, reserved opcodes
    issue(16'hA12C, 16'd300,  16'h0000, 16'h0000, "ldi_r0_300");
    issue(16'h0000, 16'd300,  16'd300,  16'd600,  "add_r0_r0");
    issue(16'h8000, 16'd600,  16'd600,  16'd600,  "out_r0_600");
    issue(16'hAFFF, 16'h03FF, 16'h0000, 16'h0000, "ldi_r3_max");
    issue(16'hED80, 16'h03FF, 16'h0000, 16'h0000, "rep_r3_r3");
    issue(16'h8C00, 16'h03FF, 16'h03FF, 16'h03FF, "out_r3");
    issue(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, "nop_011");
    issue(16'hDFFF, 16'h0000, 16'h0000, 16'h0000, "nop_110");
    issue(16'h9C00, 16'd23,   16'd23,   16'd23,   "out_r7_kept");

    // reset during T2 of add r1,r4
    issue(16'hA414, 16'd20, 16'h0000, 16'h0000, "ldi_r1_20b");
    issue(16'hB008, 16'd8,  16'h0000, 16'h0000, "ldi_r4_8b");
    issue_abort_t2(16'h0600, 16'd20, 16'd8, "add_abort");
    issue(16'h8400, 16'h0000, 16'h0000, 16'h0000, "out_r1_after_rst");
    issue(16'h9000, 16'h0000, 16'h0000, 16'h0000, "out_r4_after_rst");
    issue(16'h9C00, 16'h0000, 16'h0000, 16'h0000, "out_r7_after_rst");

    @(negedge clock);
    #1;
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- Simple multi-cycle 16-bit processor with eight general registers R0–R7, an accumulator-style ALU (registers A and G) and a shared internal bus.
- Takes one instruction word from `iin` every 4 clock cycles, executes it, and exposes the internal bus value on the `bus` output.
- Used as the top-level compute block of the system.

Parameters:
- None. The 16-bit datapath, 8 registers and 3-bit register fields are fixed.

Ports:
- `clock`  input  1  – single clock; all state updates on the rising edge.
- `resetn`  input  1  – asynchronous, active-high reset (the name is kept for codebase consistency; 1 = reset asserted).
- `iin`  input  16  – instruction word; the environment holds it stable for a full 4-cycle instruction period.
- `bus`  output  16  – current value of the internal bus multiplexer (combinational from state).

Behaviour:
- Instruction format:
  - `[15:13]` opcode, `[12:10]` Rx, `[9:7]` Ry, `[9:0]` imm10.
  - imm10 is zero-extended to 16 bits.
- Opcodes:
  - 000 add: Rx = Rx + Ry.
  - 001 sub: Rx = Rx − Ry.
  - 010 nan: Rx = ~(Rx & Ry).
  - 011 NOP (reserved).
  - 100 out: drive Rx onto `bus`.
  - 101 ldi: Rx = imm10.
  - 110 NOP (reserved).
  - 111 rep: Rx = Ry.
- Step counter: 2 bits, T0→T1→T2→T3→T0 unconditionally. Every instruction takes exactly 4 cycles, regardless of opcode.
- T0: IR <= `iin` at the edge ending T0; `bus` = 0.
- T1, decoded from IR:
  - ldi: `bus` = imm10; Rx <= `bus` at the end of T1.
  - rep: `bus` = Ry; Rx <= `bus`.
  - add/sub/nan: `bus` = Rx; A <= `bus`.
  - out: `bus` = Rx.
  - NOP: `bus` = 0.
- T2:
  - add/sub/nan: `bus` = Ry; G <= A op `bus`.
  - out: `bus` = Rx.
  - Otherwise `bus` = 0 and no writes.
- T3:
  - add/sub/nan: `bus` = G; Rx <= `bus`.
  - out: `bus` = Rx.
  - Otherwise `bus` = 0 and no writes.
- Arithmetic: unsigned modulo 2^16; carry and borrow are discarded; no flags.
- Rx == Ry is legal and uses the old value (add r0,r0 doubles R0; rep r3,r3 has no change).
- Only one register is written per cycle. A is written only in T1 of ALU ops; G only in T2 of ALU ops.
- Reset (`resetn`=1), asynchronous:
  - R0–R7, A, G and IR are set to 0; step counter goes to T0; `bus` = 0.
  - Reset mid-instruction aborts it; no partial writeback occurs after release.
  - First fetch happens at the first rising edge after reset deasserts.
- IR containing X/unknown: no defined effect is required. Benches must drive valid words before checking.

Optional Feature:
- Macro `PROC_DONE_EN`.
- When defined: adds output port `done` (1 bit), high combinationally during T3 of every instruction, 0 during reset and in T0–T2.
- When undefined: no `done` port; all other behaviour is identical.

Test Plan:
- ldi r0,#28 (0xA01C); ldi r1,#10 (0xA40A); sub r0,r1 (0x2080); out r0 (0x8000) -> `bus` = 18 (0x0012) in T1–T3 of out; R1 stays 10.
- ldi r2,#15; ldi r3,#7; nan r2,r3; rep r5,r2; out r5 -> `bus` = 0xFFF8.
- ldi r1,#20; ldi r4,#8; add r1,r4; ldi r6,#5; sub r1,r6; rep r7,r1; out r7 -> `bus` = 23.
- Wrap-around: ldi r0,#0; ldi r1,#1; sub r0,r1; out r0 -> 0xFFFF. Then add r0,r1; out r0 -> 0x0000.
- Reset mid-operation: assert `resetn` during T2 of add r1,r4 -> all registers 0 and `bus` = 0; after release, out r1 -> 0.
- Timing: during ldi, `bus` = imm in T1 and 0 in T0/T2/T3. With `PROC_DONE_EN`, `done` pulses once per 4 cycles, in T3.
